// File: rtl/compute_sequencer.sv
// Compute-stage instruction sequencer: accepts one instruction, takes its dependency
// tokens, starts and waits on the matching engine, pushes its tokens and retires it.
module compute_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_inst_valid,
    output logic             io_inst_ready,
    input  logic [127:0]     io_inst,
    input  logic             io_l2g_dep_valid,
    output logic             io_l2g_dep_ready,
    input  logic             io_s2g_dep_valid,
    output logic             io_s2g_dep_ready,
    output logic             io_g2l_dep_valid,
    input  logic             io_g2l_dep_ready,
    output logic             io_g2s_dep_valid,
    input  logic             io_g2s_dep_ready,
    output logic [127:0]     io_inst_q,
    output logic             io_uop_start,
    output logic             io_acc_start,
    output logic             io_gemm_start,
    output logic             io_alu_start,
    input  logic             io_uop_done,
    input  logic             io_acc_done,
    input  logic             io_gemm_done,
    input  logic             io_alu_done,
    output logic             io_finish,
    output logic             io_busy,
    output logic             io_err,
    output logic [CNT_W-1:0] io_inst_count
);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        EXE,
        WAIT,
        PUSH
    } seqStateT;

    seqStateT state;

    logic [2:0]  opcode;
    logic [1:0]  memId;
    logic [15:0] xSize;
    logic        popPrev;
    logic        popNext;
    logic        pushPrev;
    logic        pushNext;
    logic        isLoad;
    logic        xSizeZero;
    logic        isUop;
    logic        isAcc;
    logic        isSync;
    logic        isGemm;
    logic        isFinish;
    logic        isAlu;
    logic        isIllegal;
    logic        engineOp;
    logic        engineDone;
    logic        popGrant;
    logic        pushPending;

    // All decode works on the latched copy so it stays stable for the whole instruction.
    assign opcode    = io_inst_q[2:0];
    assign popPrev   = io_inst_q[3];
    assign popNext   = io_inst_q[4];
    assign pushPrev  = io_inst_q[5];
    assign pushNext  = io_inst_q[6];
    assign memId     = io_inst_q[8:7];
    assign xSize     = io_inst_q[95:80];

    assign isLoad    = (opcode == 3'd0);
    assign xSizeZero = (xSize == 16'd0);
    assign isUop     = isLoad && (memId == 2'd0) && !xSizeZero;
    assign isAcc     = isLoad && (memId == 2'd3) && !xSizeZero;
    assign isSync    = isLoad && ((memId == 2'd0) || (memId == 2'd3)) && xSizeZero;
    assign isGemm    = (opcode == 3'd2);
    assign isFinish  = (opcode == 3'd3);
    assign isAlu     = (opcode == 3'd4);
    assign isIllegal = !(isUop || isAcc || isSync || isGemm || isFinish || isAlu);

    assign engineOp   = isUop || isAcc || isGemm || isAlu;
    assign engineDone = (isUop && io_uop_done) || (isAcc && io_acc_done) ||
                        (isGemm && io_gemm_done) || (isAlu && io_alu_done);

    // Both required tokens are taken in the same cycle or neither is.
    assign popGrant = !reset && (state == POP) &&
                      (!popPrev || io_l2g_dep_valid) &&
                      (!popNext || io_s2g_dep_valid);

    assign io_l2g_dep_ready = popGrant && popPrev;
    assign io_s2g_dep_ready = popGrant && popNext;
    assign io_inst_ready    = (state == IDLE);
    assign io_busy          = (state != IDLE);

    assign pushPending = (io_g2l_dep_valid && !io_g2l_dep_ready) ||
                         (io_g2s_dep_valid && !io_g2s_dep_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            io_inst_q        <= '0;
            io_uop_start     <= 1'b0;
            io_acc_start     <= 1'b0;
            io_gemm_start    <= 1'b0;
            io_alu_start     <= 1'b0;
            io_g2l_dep_valid <= 1'b0;
            io_g2s_dep_valid <= 1'b0;
            io_finish        <= 1'b0;
            io_err           <= 1'b0;
            io_inst_count    <= '0;
        end else begin
            io_uop_start  <= 1'b0;
            io_acc_start  <= 1'b0;
            io_gemm_start <= 1'b0;
            io_alu_start  <= 1'b0;
            io_finish     <= 1'b0;

            case (state)
                IDLE: begin
                    if (io_inst_valid) begin
                        io_inst_q <= io_inst;
                        state     <= POP;
                    end
                end

                POP: begin
                    if (isIllegal) begin
                        io_err <= 1'b1;
                    end
                    // Start pulses are registered here so they line up with the EXE cycle.
                    if (popGrant) begin
                        io_uop_start  <= isUop;
                        io_acc_start  <= isAcc;
                        io_gemm_start <= isGemm;
                        io_alu_start  <= isAlu;
                        state         <= EXE;
                    end
                end

                EXE: begin
                    if (engineOp) begin
                        state <= WAIT;
                    end else begin
                        io_g2l_dep_valid <= pushPrev;
                        io_g2s_dep_valid <= pushNext;
                        state            <= PUSH;
                    end
                end

                WAIT: begin
                    if (engineDone) begin
                        io_g2l_dep_valid <= pushPrev;
                        io_g2s_dep_valid <= pushNext;
                        state            <= PUSH;
                    end
                end

                PUSH: begin
                    if (io_g2l_dep_ready) begin
                        io_g2l_dep_valid <= 1'b0;
                    end
                    if (io_g2s_dep_ready) begin
                        io_g2s_dep_valid <= 1'b0;
                    end
                    if (!pushPending) begin
                        io_inst_count <= io_inst_count + CNT_W'(1);
                        io_finish     <= isFinish;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compute_sequencer.sv
// Directed bench for compute_sequencer; a negedge monitor scores start pulses and
// retirements against expectations queued when each instruction is issued.
module tb_compute_sequencer;

    localparam int CNT_W = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             ioInstValid;
    logic             ioInstReady;
    logic [127:0]     ioInst;
    logic             ioL2gValid;
    logic             ioL2gReady;
    logic             ioS2gValid;
    logic             ioS2gReady;
    logic             ioG2lValid;
    logic             ioG2lReady;
    logic             ioG2sValid;
    logic             ioG2sReady;
    logic [127:0]     ioInstQ;
    logic             ioUopStart;
    logic             ioAccStart;
    logic             ioGemmStart;
    logic             ioAluStart;
    logic             ioUopDone;
    logic             ioAccDone;
    logic             ioGemmDone;
    logic             ioAluDone;
    logic             ioFinish;
    logic             ioBusy;
    logic             ioErr;
    logic [CNT_W-1:0] ioInstCount;

    typedef struct {
        logic [3:0]       startVec;
        logic             finish;
        logic [CNT_W-1:0] count;
    } sbEntryT;

    sbEntryT          sbq[$];
    sbEntryT          popped;
    int               assertCount = 0;
    int               failCount = 0;
    logic [CNT_W-1:0] expCount;
    logic [CNT_W-1:0] prevCount;
    logic             seenStart;
    logic [3:0]       startNow;
    logic [127:0]     inst;
    int               latency;
    int               busyCycles;
    int               g2lCycles;
    int               g2sCycles;
    int               pushCycles;

    compute_sequencer #(.CNT_W(CNT_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_inst_valid    (ioInstValid),
        .io_inst_ready    (ioInstReady),
        .io_inst          (ioInst),
        .io_l2g_dep_valid (ioL2gValid),
        .io_l2g_dep_ready (ioL2gReady),
        .io_s2g_dep_valid (ioS2gValid),
        .io_s2g_dep_ready (ioS2gReady),
        .io_g2l_dep_valid (ioG2lValid),
        .io_g2l_dep_ready (ioG2lReady),
        .io_g2s_dep_valid (ioG2sValid),
        .io_g2s_dep_ready (ioG2sReady),
        .io_inst_q        (ioInstQ),
        .io_uop_start     (ioUopStart),
        .io_acc_start     (ioAccStart),
        .io_gemm_start    (ioGemmStart),
        .io_alu_start     (ioAluStart),
        .io_uop_done      (ioUopDone),
        .io_acc_done      (ioAccDone),
        .io_gemm_done     (ioGemmDone),
        .io_alu_done      (ioAluDone),
        .io_finish        (ioFinish),
        .io_busy          (ioBusy),
        .io_err           (ioErr),
        .io_inst_count    (ioInstCount)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Waits for the instruction slot, issues one instruction and queues what its retirement must look like.
    task automatic applyStimulus(input logic [127:0] word, input logic [3:0] expStart,
                                 input logic expFinish);
        sbEntryT entry;
        int n = 0;
        while (!ioInstReady && n < 50) begin
            tick();
            n++;
        end
        checkOutput("instReadyWait", 128'(ioInstReady), 128'(1));
        expCount       = expCount + CNT_W'(1);
        entry.startVec = expStart;
        entry.finish   = expFinish;
        entry.count    = expCount;
        sbq.push_back(entry);
        ioInst      = word;
        ioInstValid = 1'b1;
        tick();
        ioInstValid = 1'b0;
    endtask

    task automatic waitRetire();
        int n = 0;
        while (ioInstCount !== expCount && n < 50) begin
            tick();
            n++;
        end
        checkOutput("retireWait", 128'(ioInstCount), 128'(expCount));
    endtask

    // Monitor: start vector must match the queued instruction; each count step pops one entry.
    initial begin
        forever begin
            @(negedge clock);
            startNow = {ioAluStart, ioGemmStart, ioAccStart, ioUopStart};
            if (reset) begin
                prevCount = ioInstCount;
                seenStart = 1'b0;
            end else begin
                if (startNow !== 4'b0000) begin
                    if (sbq.size() == 0) begin
                        checkOutput("startUnexpected", 128'(startNow), 128'(0));
                    end else begin
                        checkOutput("startKind", 128'(startNow), 128'(sbq[0].startVec));
                        seenStart = 1'b1;
                    end
                end
                if (ioInstCount !== prevCount) begin
                    if (sbq.size() == 0) begin
                        checkOutput("retireUnexpected", 128'(ioInstCount), 128'(prevCount));
                    end else begin
                        popped = sbq.pop_front();
                        checkOutput("retireCount", 128'(ioInstCount), 128'(popped.count));
                        checkOutput("retireFinish", 128'(ioFinish), 128'(popped.finish));
                        checkOutput("retireStartSeen", 128'(seenStart),
                                    128'(popped.startVec != 4'b0000));
                    end
                    seenStart = 1'b0;
                    prevCount = ioInstCount;
                end else begin
                    checkOutput("finishWithoutRetire", 128'(ioFinish), 128'(0));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ioInstValid = 1'b0;
        ioInst      = '0;
        ioL2gValid  = 1'b0;
        ioS2gValid  = 1'b0;
        ioG2lReady  = 1'b0;
        ioG2sReady  = 1'b0;
        ioUopDone   = 1'b0;
        ioAccDone   = 1'b0;
        ioGemmDone  = 1'b0;
        ioAluDone   = 1'b0;
        expCount    = '0;
        reset       = 1'b1;
        tick();
        tick();

        checkOutput("rstInstReady", 128'(ioInstReady), 128'(1));
        checkOutput("rstBusy", 128'(ioBusy), 128'(0));
        checkOutput("rstErr", 128'(ioErr), 128'(0));
        checkOutput("rstCount", 128'(ioInstCount), 128'(0));
        checkOutput("rstInstQ", ioInstQ, 128'(0));
        checkOutput("rstPopReady", 128'({ioL2gReady, ioS2gReady}), 128'(0));
        checkOutput("rstPushValid", 128'({ioG2lValid, ioG2sValid}), 128'(0));
        checkOutput("rstStarts", 128'({ioAluStart, ioGemmStart, ioAccStart, ioUopStart}), 128'(0));
        checkOutput("rstFinish", 128'(ioFinish), 128'(0));
        reset = 1'b0;

        // Sync, no deps: the acceptance cycle counts as the first of four; busy covers POP, EXE, PUSH.
        applyStimulus(128'h0, 4'b0000, 1'b0);
        latency    = 1;
        busyCycles = 0;
        while (ioInstCount !== expCount && latency < 20) begin
            if (ioBusy) busyCycles++;
            tick();
            latency++;
        end
        checkOutput("syncLatency", 128'(latency), 128'(4));
        checkOutput("syncBusyCycles", 128'(busyCycles), 128'(3));
        checkOutput("syncBusyAfter", 128'(ioBusy), 128'(0));
        checkOutput("syncInstQ", ioInstQ, 128'(0));

        // GEMM with pop_prev: token arrives after five cycles in POP.
        applyStimulus(128'hA, 4'b0100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("gemmHoldReady", 128'(ioL2gReady), 128'(0));
            tick();
        end
        ioL2gValid = 1'b1;
        #1;
        checkOutput("gemmL2gReady", 128'(ioL2gReady), 128'(1));
        checkOutput("gemmS2gReady", 128'(ioS2gReady), 128'(0));
        tick();
        ioL2gValid = 1'b0;
        checkOutput("gemmStart", 128'(ioGemmStart), 128'(1));
        checkOutput("gemmL2gReadyOnce", 128'(ioL2gReady), 128'(0));
        repeat (10) tick();
        ioGemmDone = 1'b1;
        tick();
        ioGemmDone = 1'b0;
        checkOutput("gemmNotYetRetired", 128'(ioInstCount), 128'(expCount - CNT_W'(1)));
        tick();
        checkOutput("gemmRetire", 128'(ioInstCount), 128'(expCount));

        // ALU with both pops and both pushes; s2g token lags l2g by three cycles.
        inst          = '0;
        inst[2:0]     = 3'd4;
        inst[6:3]     = 4'hF;
        inst[109:108] = 2'd2;
        applyStimulus(inst, 4'b1000, 1'b0);
        ioL2gValid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("aluHalfTokens", 128'({ioL2gReady, ioS2gReady}), 128'(0));
            tick();
        end
        ioS2gValid = 1'b1;
        #1;
        checkOutput("aluBothReady", 128'({ioL2gReady, ioS2gReady}), 128'(2'b11));
        tick();
        ioL2gValid = 1'b0;
        ioS2gValid = 1'b0;
        checkOutput("aluStart", 128'(ioAluStart), 128'(1));
        tick();
        tick();
        tick();
        ioAluDone = 1'b1;
        tick();
        ioAluDone  = 1'b0;
        ioG2lReady = 1'b1;
        checkOutput("aluPushEntry", 128'({ioG2lValid, ioG2sValid}), 128'(2'b11));
        g2lCycles  = 0;
        g2sCycles  = 0;
        pushCycles = 0;
        while (ioInstCount !== expCount && pushCycles < 20) begin
            if (ioG2lValid) g2lCycles++;
            if (ioG2sValid) g2sCycles++;
            if (pushCycles == 4) ioG2sReady = 1'b1;
            tick();
            ioG2lReady = 1'b0;
            pushCycles++;
        end
        ioG2sReady = 1'b0;
        checkOutput("aluG2lCycles", 128'(g2lCycles), 128'(1));
        checkOutput("aluG2sCycles", 128'(g2sCycles), 128'(5));
        checkOutput("aluPushCycles", 128'(pushCycles), 128'(5));
        checkOutput("aluPushCleared", 128'({ioG2lValid, ioG2sValid}), 128'(0));

        // Load uop: a stray gemm_done in WAIT must not retire it.
        inst          = '0;
        inst[95:80]   = 16'd16;
        applyStimulus(inst, 4'b0001, 1'b0);
        tick();
        checkOutput("uopStartOnly", 128'({ioAluStart, ioGemmStart, ioAccStart, ioUopStart}), 128'(4'b0001));
        tick();
        ioGemmDone = 1'b1;
        tick();
        ioGemmDone = 1'b0;
        tick();
        checkOutput("strayDoneBusy", 128'(ioBusy), 128'(1));
        checkOutput("strayDoneNoRetire", 128'(ioInstCount), 128'(expCount - CNT_W'(1)));
        ioUopDone = 1'b1;
        tick();
        ioUopDone = 1'b0;
        waitRetire();

        // Load acc: a done coinciding with the start cycle is ignored.
        inst          = '0;
        inst[8:7]     = 2'd3;
        inst[95:80]   = 16'd8;
        applyStimulus(inst, 4'b0010, 1'b0);
        tick();
        checkOutput("accStartOnly", 128'({ioAluStart, ioGemmStart, ioAccStart, ioUopStart}), 128'(4'b0010));
        ioAccDone = 1'b1;
        tick();
        ioAccDone = 1'b0;
        tick();
        checkOutput("accEarlyDoneBusy", 128'(ioBusy), 128'(1));
        checkOutput("accEarlyDoneNoRetire", 128'(ioInstCount), 128'(expCount - CNT_W'(1)));
        ioAccDone = 1'b1;
        tick();
        ioAccDone = 1'b0;
        waitRetire();

        // FINISH pulses once at retire; illegal opcode 5 sets a sticky error.
        applyStimulus(128'h3, 4'b0000, 1'b1);
        waitRetire();
        checkOutput("finishPulse", 128'(ioFinish), 128'(1));
        tick();
        checkOutput("finishPulseEnds", 128'(ioFinish), 128'(0));
        checkOutput("errBeforeIllegal", 128'(ioErr), 128'(0));
        applyStimulus(128'h5, 4'b0000, 1'b0);
        waitRetire();
        checkOutput("errSet", 128'(ioErr), 128'(1));
        applyStimulus(128'h0, 4'b0000, 1'b0);
        waitRetire();
        checkOutput("errSticky", 128'(ioErr), 128'(1));

        // Reset while a GEMM is in WAIT drops it and restores every reset value.
        applyStimulus(128'h2, 4'b0100, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        sbq.delete();
        expCount = '0;
        checkOutput("midRstInstReady", 128'(ioInstReady), 128'(1));
        checkOutput("midRstBusy", 128'(ioBusy), 128'(0));
        checkOutput("midRstErr", 128'(ioErr), 128'(0));
        checkOutput("midRstCount", 128'(ioInstCount), 128'(0));
        checkOutput("midRstInstQ", ioInstQ, 128'(0));
        checkOutput("midRstStarts", 128'({ioAluStart, ioGemmStart, ioAccStart, ioUopStart}), 128'(0));
        checkOutput("midRstPush", 128'({ioG2lValid, ioG2sValid, ioFinish}), 128'(0));
        tick();
        reset = 1'b0;
        applyStimulus(128'h0, 4'b0000, 1'b0);
        waitRetire();
        checkOutput("postRstCount", 128'(ioInstCount), 128'(1));
        tick();
        checkOutput("scoreboardDrained", 128'(sbq.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
